dmem_bridge: RTL and testbench
==============================

// Module: dmem_bridge
// PURPOSE
// - Data-side bridge between mips_core MEM-stage port and a multi-cycle data memory with req/ack handshake.
// - Posts stores into a write buffer (no stall unless full); stalls loads until the buffer is drained and read data returns.
// - Drives ram_stall/ram_cs into the pipeline controller; sits directly downstream of the core's mem_* interface.
// PARAMETERS
// - WB_DEPTH  4   write-buffer entries (power of 2, >=2)
// - AW        32  address width on both sides
// PORTS
// - clk        in   1   main clock
// - rst        in   1   asynchronous, active-low reset (0 = reset)
// - mem_ren    in   1   core load request (held stable while ram_stall=1)
// - mem_wen    in   1   core store request (held stable while ram_stall=1)
// - mem_addr   in   AW  core byte address; [1:0] ignored (word access only)
// - mem_dout   in   32  core store data
// - mem_din    out  32  load data to core, valid in the cycle ram_stall falls for a load
// - ram_stall  out  1   stall MEM and upstream stages
// - ram_cs     out  1   = mem_ren | mem_wen (combinational)
// - bus_req    out  1   memory request, held until bus_ack
// - bus_we     out  1   1 = write, 0 = read
// - bus_addr   out  AW  word address {addr[AW-1:2],2'b00}
// - bus_wdata  out  32  write data
// - bus_rdata  in   32  read data, sampled when bus_ack=1
// - bus_ack    in   1   one-cycle completion; transfer done on clk edge with bus_req & bus_ack
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, FIFO empty, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, mem_din=0; ram_stall=0.
// - FSM states: IDLE, WDRAIN, RREQ, RDONE (encodings in define.vh).
// - Store: mem_wen=1 and FIFO not full -> push {addr,data} same edge, ram_stall=0 (zero added latency).
//   FIFO full -> ram_stall=1 until a slot frees; push on the edge where ram_stall=0.
//   Push and pop in the same cycle with FIFO full: pop frees slot, push accepted next cycle (stall stays 1 that cycle).
// - Drain: IDLE with FIFO non-empty -> WDRAIN; bus_req=1, bus_we=1, head entry on bus; on ack pop, return IDLE
//   (re-issue next cycle if still non-empty; one idle bus cycle between transfers is required).
// - Load: mem_ren=1 -> ram_stall=1 immediately (combinational). Loads issue only when FIFO empty and state IDLE
//   (strict store->load ordering, no address compare). IDLE -> RREQ: bus_req=1, bus_we=0.
//   RREQ + bus_ack -> latch bus_rdata into mem_din, -> RDONE. RDONE: ram_stall=0 for exactly one cycle, -> IDLE.
//   Minimum load latency with ack in first RREQ cycle: 3 cycles of ram_cs (stall, stall, release).
// - mem_ren and mem_wen both 1: illegal; bridge treats as store, load ignored.
// - In RDONE the core's held mem_ren is not re-issued; a new load is recognised only from the following cycle.
// - bus_req never drops before bus_ack; bus_addr/bus_we/bus_wdata constant while bus_req=1.
// - bus_ack while bus_req=0: ignored.
// - Reset mid-transfer: bus_req drops asynchronously, buffered stores discarded; memory must tolerate abandon.
// - FIFO pointers log2(WB_DEPTH)+1 bits; wrap modulo 2*WB_DEPTH; full when MSBs differ and low bits equal.
// STRUCTURE
// - define.vh: FSM state localparams (DB_IDLE, DB_WDRAIN, DB_RREQ, DB_RDONE), DB_ST_W width.
// - Sub-module wbuf_fifo (WB_DEPTH x {AW,32}, push/pop/full/empty/head, same async active-low rst).
// - FSM, stall logic and bus mux in dmem_bridge; no other hierarchy.
// TESTING
// - Load, empty FIFO, ack after 2 wait cycles, rdata=0xDEADBEEF -> ram_stall high 4 cycles, mem_din=0xDEADBEEF on release.
// - 4 back-to-back stores (WB_DEPTH=4), bus_ack held 0 -> no stall on 1-4, 5th store stalls until first ack pops.
// - Store 0x10<=0x1234 then load 0x10 -> bus shows write before read; load returns memory value, read never precedes write.
// - Reset asserted in RREQ with bus_req=1 -> bus_req=0 and ram_stall=0 same cycle, FIFO empty, mem_din=0.
// - mem_addr=0x0000_0013 store -> bus_addr=0x0000_0010; mem_ren&mem_wen=1 -> treated as store, no read issued.
// - Random ack delay 0-7 cycles, 1000 mixed ops vs reference memory model -> all loads match, bus_req stable until ack.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// rtl/dmem_bridge_pkg.sv - shared FSM encodings for the data-memory bridge
// Purpose : state width and state codes used by dmem_bridge.
// Contents: DB_ST_W, db_state_t, DB_IDLE / DB_WDRAIN / DB_RREQ / DB_RDONE.
package dmem_bridge_pkg;

  localparam int DB_ST_W = 2;

  typedef logic [DB_ST_W-1:0] db_state_t;

  localparam db_state_t DB_IDLE   = 2'd0;
  localparam db_state_t DB_WDRAIN = 2'd1;
  localparam db_state_t DB_RREQ   = 2'd2;
  localparam db_state_t DB_RDONE  = 2'd3;

endpackage

// File: rtl/dmem_bridge_wbuf_fifo.sv
// rtl/dmem_bridge_wbuf_fifo.sv - posted-store write buffer for dmem_bridge
// Purpose : DEPTH-entry FIFO of {word address, store data}.
// Ports   : clk, rst (async, active-low)
//           i_push/i_addr/i_data  - enqueue (ignored when full)
//           i_pop                 - dequeue head (ignored when empty)
//           o_full/o_empty        - occupancy flags
//           o_head_addr/o_head_data - oldest entry
module wbuf_fifo
  import dmem_bridge_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_data,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW-1:0] o_head_addr,
  output logic [31:0]   o_head_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [AW-1:0] r_addr_q [DEPTH];
  logic [31:0]   r_data_q [DEPTH];
  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  logic          w_do_push;
  logic          w_do_pop;

  // Extra pointer MSB separates full (laps differ) from empty (same lap).
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only visible behind a valid pointer.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_addr_q[r_wptr[PW-1:0]] <= i_addr;
      r_data_q[r_wptr[PW-1:0]] <= i_data;
    end
  end

  assign o_head_addr = r_addr_q[r_rptr[PW-1:0]];
  assign o_head_data = r_data_q[r_rptr[PW-1:0]];

endmodule

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - MEM-stage data bridge with posted write buffer
// Purpose : posts stores into wbuf_fifo, drains them over a req/ack bus,
//           stalls loads until the buffer is empty and read data returns.
// Ports   : clk, rst (async, active-low)
//           core side : mem_ren, mem_wen, mem_addr, mem_dout -> mem_din, ram_stall, ram_cs
//           bus side  : bus_req, bus_we, bus_addr, bus_wdata <- bus_rdata, bus_ack
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int WB_DEPTH = 4,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_ren,
  input  logic          mem_wen,
  input  logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_dout,
  output logic [31:0]   mem_din,
  output logic          ram_stall,
  output logic          ram_cs,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [31:0]   bus_wdata,
  input  logic [31:0]   bus_rdata,
  input  logic          bus_ack
);

  db_state_t     r_state;
  db_state_t     w_next;
  logic [AW-1:0] r_raddr;
  logic [31:0]   r_din;
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_head_addr;
  logic [31:0]   w_head_data;
  logic          w_load;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_rd_start;

  // A store wins when both strobes are set.
  assign w_load     = mem_ren & ~mem_wen;
  assign w_waddr    = mem_addr & ~AW'(3);
  assign w_push     = mem_wen & ~w_full;
  assign w_rd_start = (r_state == DB_IDLE) & w_empty & w_load;

  assign ram_cs  = mem_ren | mem_wen;
  assign mem_din = r_din;

  // Full-buffer stall uses the registered flag, so a pop in the same cycle
  // still stalls and the store is taken on the following edge.
  assign ram_stall = rst & (w_load ? (r_state != DB_RDONE) : (mem_wen & w_full));

  wbuf_fifo #(
    .DEPTH (WB_DEPTH),
    .AW    (AW)
  ) u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_addr      (w_waddr),
    .i_data      (mem_dout),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= DB_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DB_IDLE: begin
        if (!w_empty)    w_next = DB_WDRAIN;
        else if (w_load) w_next = DB_RREQ;
      end
      DB_WDRAIN: if (bus_ack) w_next = DB_IDLE;
      DB_RREQ:   if (bus_ack) w_next = DB_RDONE;
      default:   w_next = DB_IDLE;
    endcase
  end

  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    w_pop     = 1'b0;
    case (r_state)
      DB_WDRAIN: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = w_head_addr;
        bus_wdata = w_head_data;
        w_pop     = bus_ack;
      end
      DB_RREQ: begin
        bus_req  = 1'b1;
        bus_addr = r_raddr;
      end
      default: ;
    endcase
  end

  // Read address is captured at issue so the bus stays stable even if the
  // core's address wiggles while the request is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_raddr <= '0;
      r_din   <= '0;
    end else begin
      if (w_rd_start) r_raddr <= w_waddr;
      if ((r_state == DB_RREQ) && bus_ack) r_din <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - directed self-checking bench for dmem_bridge
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        ram_stall, ram_cs;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;

  always #5 clk = ~clk;

  dmem_bridge #(.WB_DEPTH(4), .AW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .ram_stall (ram_stall),
    .ram_cs    (ram_cs),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder and bus log
  logic        ack_en = 1'b1;
  int          ack_delay = 0;
  logic        spur = 1'b0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  logic        log_we [$];

  initial begin
    int          wcnt;
    logic        have;
    logic [31:0] c_addr, c_wd;
    logic        c_we;
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    have = 1'b0;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #3;
      if (bus_req) begin
        if (!have) begin
          have = 1'b1; wcnt = 0;
          c_addr = bus_addr; c_we = bus_we; c_wd = bus_wdata;
        end else begin
          chk("req_addr_stable", bus_addr, c_addr);
          chk("req_we_stable", {31'b0, bus_we}, {31'b0, c_we});
          chk("req_wdata_stable", bus_wdata, c_wd);
        end
        if (ack_en && wcnt >= ack_delay) begin
          bus_ack = 1'b1;
          if (bus_we) mem[bus_addr] = bus_wdata;
          else bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
          log_addr.push_back(bus_addr);
          log_data.push_back(bus_we ? bus_wdata : bus_rdata);
          log_we.push_back(bus_we);
          have = 1'b0;
        end else begin
          bus_ack = 1'b0;
          wcnt++;
        end
      end else begin
        bus_ack = spur;
        have = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at a later negedge with inputs released.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    int g;
    mem_wen = 1'b1; mem_addr = a; mem_dout = d;
    #1;
    g = 0;
    while (ram_stall && g < 100) begin @(negedge clk); #1; g++; end
    chk("store_accept", {31'b0, ram_stall}, 32'h0);
    @(negedge clk);
    mem_wen = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output int stalls, output logic [31:0] din);
    int g;
    mem_ren = 1'b1; mem_addr = a;
    #1;
    stalls = 0; g = 0;
    while (ram_stall && g < 100) begin stalls++; @(negedge clk); #1; g++; end
    chk("load_release", {31'b0, ram_stall}, 32'h0);
    din = mem_din;
    @(negedge clk);
    mem_ren = 1'b0;
  endtask

  task automatic wait_log(input int n);
    int g;
    g = 0;
    while (log_we.size() < n && g < 100) begin @(negedge clk); g++; end
  endtask

  // Mixed directed vectors: op 1 = load (data is expected value)
  logic        mx_ld   [10] = '{0, 0, 1, 0, 1, 1, 0, 0, 1, 1};
  logic [31:0] mx_addr [10] = '{32'h100, 32'h104, 32'h100, 32'h100, 32'h100,
                                32'h104, 32'h108, 32'h10C, 32'h10C, 32'h10B};
  logic [31:0] mx_data [10] = '{32'h11111111, 32'h22222222, 32'h11111111, 32'h33333333, 32'h33333333,
                                32'h22222222, 32'h44444444, 32'h55555555, 32'h55555555, 32'h44444444};
  int          mx_dly  [10] = '{3, 0, 5, 7, 1, 0, 2, 6, 4, 0};

  initial begin
    int          s, g, h, base;
    logic [31:0] d;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = 32'h0; mem_dout = 32'h0;
    #2;
    chk("rst_bus_req", {31'b0, bus_req}, 32'h0);
    chk("rst_bus_we", {31'b0, bus_we}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    mem_ren = 1'b1;
    #1;
    chk("rst_stall_gated", {31'b0, ram_stall}, 32'h0);
    chk("ram_cs_comb", {31'b0, ram_cs}, 32'h1);
    mem_ren = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Load with two wait cycles
    mem[32'h40] = 32'hDEADBEEF;
    ack_delay = 2;
    do_load(32'h40, s, d);
    chk("load_stall_cycles", s, 4);
    chk("load_data", d, 32'hDEADBEEF);

    // Four posted stores, fifth stalls until the first pop
    ack_en = 1'b0; ack_delay = 0;
    base = log_we.size();
    for (int i = 0; i < 4; i++) begin
      mem_wen = 1'b1; mem_addr = 32'h20 + 32'(4 * i); mem_dout = 32'hA0 + 32'(i);
      #1;
      chk("store_nostall", {31'b0, ram_stall}, 32'h0);
      @(negedge clk);
    end
    mem_addr = 32'h30; mem_dout = 32'hA4;
    s = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (ram_stall) s++;
      if (c < 2) @(negedge clk);
    end
    ack_en = 1'b1;
    @(negedge clk);
    #1;
    g = 0;
    while (ram_stall && g < 50) begin s++; @(negedge clk); #1; g++; end
    chk("store5_stall_cycles", s, 4);
    @(negedge clk);
    mem_wen = 1'b0;
    wait_log(base + 5);
    chk("drain_count", log_we.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      chk("drain_addr", log_addr[base + i], 32'h20 + 32'(4 * i));
      chk("drain_data", log_data[base + i], 32'hA0 + 32'(i));
    end

    // Store then load same address: write must reach the bus first
    ack_delay = 1;
    base = log_we.size();
    do_store(32'h10, 32'h1234);
    do_load(32'h10, s, d);
    chk("st_ld_stalls", s, 6);
    chk("st_ld_data", d, 32'h1234);
    chk("st_ld_first_we", {31'b0, log_we[base]}, 32'h1);
    chk("st_ld_second_we", {31'b0, log_we[base + 1]}, 32'h0);
    chk("st_ld_rd_addr", log_addr[base + 1], 32'h10);

    // Unaligned store address is forced to a word boundary
    ack_delay = 0;
    base = log_we.size();
    do_store(32'h13, 32'hA5A5);
    wait_log(base + 1);
    chk("align_addr", log_addr[base], 32'h10);
    chk("align_data", log_data[base], 32'hA5A5);

    // Both strobes: store only, no read issued
    base = log_we.size();
    mem_ren = 1'b1; mem_wen = 1'b1; mem_addr = 32'h24; mem_dout = 32'h77;
    #1;
    chk("both_nostall", {31'b0, ram_stall}, 32'h0);
    @(negedge clk);
    mem_ren = 1'b0; mem_wen = 1'b0;
    repeat (8) @(negedge clk);
    chk("both_one_xfer", log_we.size() - base, 1);
    chk("both_is_write", {31'b0, log_we[base]}, 32'h1);
    chk("both_addr", log_addr[base], 32'h24);
    chk("both_din_kept", mem_din, 32'h1234);

    // Reset while a read is outstanding
    ack_delay = 7;
    mem_ren = 1'b1; mem_addr = 32'h80;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rreq_bus_req", {31'b0, bus_req}, 32'h1);
    chk("rreq_bus_we", {31'b0, bus_we}, 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("rreq_rst_bus_req", {31'b0, bus_req}, 32'h0);
    chk("rreq_rst_stall", {31'b0, ram_stall}, 32'h0);
    chk("rreq_rst_din", mem_din, 32'h0);
    @(negedge clk);
    mem_ren = 1'b0; rst = 1'b1;

    // Reset discards buffered stores
    ack_en = 1'b0;
    do_store(32'h200, 32'h1);
    do_store(32'h204, 32'h2);
    do_store(32'h208, 32'h3);
    @(negedge clk);
    #1;
    chk("wdrain_bus_req", {31'b0, bus_req}, 32'h1);
    #1 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; ack_en = 1'b1; ack_delay = 0;
    base = log_we.size();
    h = 0;
    repeat (6) begin @(negedge clk); #1; if (bus_req) h++; end
    chk("discard_no_req", h, 0);
    chk("discard_no_xfer", log_we.size() - base, 0);
    @(negedge clk);
    do_load(32'h200, s, d);
    chk("discard_mem", d, 32'h0);

    // Ack without request is ignored
    spur = 1'b1;
    h = 0;
    repeat (3) begin @(negedge clk); #1; if (bus_req) h++; end
    spur = 1'b0;
    chk("spur_no_req", h, 0);
    chk("spur_din_kept", mem_din, 32'h0);
    @(negedge clk);

    // Mixed directed sequence with varied ack delays
    for (int i = 0; i < 10; i++) begin
      ack_delay = mx_dly[i];
      if (mx_ld[i]) begin
        do_load(mx_addr[i], s, d);
        chk("mix_load", d, mx_data[i]);
      end else begin
        do_store(mx_addr[i], mx_data[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1);
  end

endmodule
